// File: rtl/issue_scheduler.sv
// Issue scheduler with register-hazard interlock between fetch and decoder_32.
// Latency: one cycle from accept to out_instruction; bubbles are also one cycle.
// Backpressure: in_ready drops while the offered instruction has a hazard; never stalled from downstream.
//
// Ports:
//   clk, reset            - single rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     - fetch handshake; in_ready is combinational and ignores in_valid
//   in_instruction        - MIPS word, held stable by fetch while refused
//   out_valid             - out_instruction carries a real instruction
//   out_instruction       - registered word for decode, 32'h0 on bubble or idle
//   out_stall             - one cycle high per hazard bubble
//   stall_count           - saturating count of hazard bubbles
//
// Optional build macro ISSUE_FWD_EN: a forwarding datapath exists downstream,
// so only load-use against the newest scoreboard entry interlocks.
module issue_scheduler #(
  parameter int DEPTH = 2,   // issue-to-writeback distance, legal 1..4
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [31:0]      in_instruction,
  output logic             in_ready,
  output logic             out_valid,
  output logic [31:0]      out_instruction,
  output logic             out_stall,
  output logic [CNT_W-1:0] stall_count
);

  typedef struct packed {
    logic       vld;
    logic [4:0] rd;
    logic       is_load;
  } sb_entry_t;

  // Entry 0 is the most recent issue slot; the run/stall condition is not
  // kept separately, out_stall already records whether the last slot bubbled.
  sb_entry_t sb [DEPTH];

  logic [5:0] op;
  logic [4:0] rs, rt, rd;
  assign op = in_instruction[31:26];
  assign rs = in_instruction[25:21];
  assign rt = in_instruction[20:16];
  assign rd = in_instruction[15:11];

  logic [4:0] dst;
  logic       dst_load;
  logic       use_rs, use_rt;
  sb_entry_t  new_entry;

  always_comb begin
    dst      = 5'd0;
    dst_load = 1'b0;
    use_rs   = 1'b0;
    use_rt   = 1'b0;
    case (op)
      6'h00: begin                                   // R-type
        dst    = rd;
        use_rs = 1'b1;
        use_rt = 1'b1;
      end
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
        dst    = rt;
        use_rs = 1'b1;
      end
      6'h23: begin                                   // lw
        dst      = rt;
        dst_load = 1'b1;
        use_rs   = 1'b1;
      end
      6'h03: dst = 5'd31;                            // jal
      6'h02: ;                                       // j
      6'h2B, 6'h04, 6'h05: begin                     // sw, beq, bne
        use_rs = 1'b1;
        use_rt = 1'b1;
      end
      default: use_rs = 1'b1;
    endcase
    // A write to $0 is discarded, so it never creates a dependency.
    new_entry.vld     = |dst;
    new_entry.rd      = dst;
    new_entry.is_load = dst_load & (|dst);
  end

  logic src_rs_vld, src_rt_vld;
  assign src_rs_vld = use_rs && (rs != 5'd0);
  assign src_rt_vld = use_rt && (rt != 5'd0);

  // The check runs against the scoreboard before this instruction enters it,
  // so an instruction reading its own destination only sees older producers.
  logic hazard;
  always_comb begin
    hazard = 1'b0;
`ifdef ISSUE_FWD_EN
    if (sb[0].vld && sb[0].is_load &&
        ((src_rs_vld && (rs == sb[0].rd)) || (src_rt_vld && (rt == sb[0].rd))))
      hazard = 1'b1;
`else
    for (int i = 0; i < DEPTH; i++) begin
      if (sb[i].vld &&
          ((src_rs_vld && (rs == sb[i].rd)) || (src_rt_vld && (rt == sb[i].rd))))
        hazard = 1'b1;
    end
`endif
  end

  logic accept;
  assign in_ready = !reset && !hazard;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid       <= 1'b0;
      out_instruction <= 32'h0;
      out_stall       <= 1'b0;
      stall_count     <= '0;
      for (int i = 0; i < DEPTH; i++) sb[i] <= '0;
    end else begin
      out_valid       <= accept;
      out_instruction <= accept ? in_instruction : 32'h0;
      out_stall       <= in_valid && hazard;
      if (in_valid && hazard && (stall_count != {CNT_W{1'b1}}))
        stall_count <= stall_count + CNT_W'(1);
      // Bubbles and idle slots push an invalid entry so producers age out.
      sb[0] <= accept ? new_entry : '0;
      for (int i = 1; i < DEPTH; i++) sb[i] <= sb[i-1];
    end
  end

  // The oldest entry only feeds the hazard compare (and not at all when
  // forwarding is built in); it is never shifted further.
  logic unused_tail;
  assign unused_tail = ^sb[DEPTH-1];

endmodule

// File: tb/tb_issue_scheduler.sv
module tb_issue_scheduler;

  localparam int DEPTH = 2;
  localparam int CNT_W = 16;
`ifdef ISSUE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic [31:0]      in_instruction;
  logic             in_ready;
  logic             out_valid;
  logic [31:0]      out_instruction;
  logic             out_stall;
  logic [CNT_W-1:0] stall_count;

  issue_scheduler #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_instruction  (in_instruction),
    .in_ready        (in_ready),
    .out_valid       (out_valid),
    .out_instruction (out_instruction),
    .out_stall       (out_stall),
    .stall_count     (stall_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: a history of issued producers, each tagged with the
  // cycle it issued; a dependent is blocked while the age is 1..DEPTH.
  int         cyc = 0;
  int         h_cyc[$];
  int         h_dst[$];
  bit         h_ld[$];
  logic       exp_v;
  logic [31:0] exp_i;
  logic       exp_s;
  int         exp_c;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int m_dest(input logic [31:0] w);
    int op = int'(w[31:26]);
    if (op == 0) return int'(w[15:11]);
    if ((op >= 8 && op <= 15) || op == 'h23) return int'(w[20:16]);
    if (op == 3) return 31;
    return 0;
  endfunction

  function automatic bit m_hazard(input logic [31:0] w);
    int op = int'(w[31:26]);
    int a = 0;
    int b = 0;
    if (op == 0 || op == 'h2B || op == 4 || op == 5) begin
      a = int'(w[25:21]);
      b = int'(w[20:16]);
    end else if (op != 2 && op != 3) begin
      a = int'(w[25:21]);
    end
    foreach (h_cyc[k]) begin
      int  age = cyc - h_cyc[k];
      bit  live = FWD ? (age == 1 && h_ld[k]) : (age >= 1 && age <= DEPTH);
      if (live && ((a != 0 && a == h_dst[k]) || (b != 0 && b == h_dst[k])))
        return 1'b1;
    end
    return 1'b0;
  endfunction

  // One clock: check in_ready before the edge, advance the model at the edge,
  // check registered outputs just after it.
  task automatic tick();
    bit hz;
    #1;
    hz = m_hazard(in_instruction);
    chk("in_ready", 32'(in_ready), 32'(!reset && !hz));
    @(posedge clk);
    if (reset) begin
      exp_v = 0; exp_i = 0; exp_s = 0; exp_c = 0;
      h_cyc.delete(); h_dst.delete(); h_ld.delete();
    end else if (in_valid && !hz) begin
      exp_v = 1; exp_i = in_instruction; exp_s = 0;
      if (m_dest(in_instruction) != 0) begin
        h_cyc.push_back(cyc);
        h_dst.push_back(m_dest(in_instruction));
        h_ld.push_back(in_instruction[31:26] == 6'h23);
      end
    end else if (in_valid) begin
      exp_v = 0; exp_i = 0; exp_s = 1;
      if (exp_c < (1 << CNT_W) - 1) exp_c++;
    end else begin
      exp_v = 0; exp_i = 0; exp_s = 0;
    end
    cyc++;
    while (h_cyc.size() > 0 && cyc - h_cyc[0] > DEPTH) begin
      void'(h_cyc.pop_front()); void'(h_dst.pop_front()); void'(h_ld.pop_front());
    end
    #1;
    chk("out_valid", 32'(out_valid), 32'(exp_v));
    chk("out_instruction", out_instruction, exp_i);
    chk("out_stall", 32'(out_stall), 32'(exp_s));
    chk("stall_count", 32'(stall_count), 32'(exp_c));
  endtask

  // Offer one instruction until it issues; report the bubbles seen.
  task automatic issue(input logic [31:0] ins, output int bubbles);
    bit done = 1'b0;
    in_valid = 1'b1;
    in_instruction = ins;
    bubbles = 0;
    for (int n = 0; n < 8 && !done; n++) begin
      tick();
      if (out_stall === 1'b1) bubbles++;
      if (out_valid === 1'b1 && out_instruction === ins) done = 1'b1;
    end
    chk("issue_done", 32'(done), 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int  b;
    bit  hold;
    reset = 1'b1;
    in_valid = 1'b1;
    in_instruction = 32'h20100000;

    // Reset held two cycles with a valid offer.
    tick();
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instruction, 32'h0);
    chk("rst_stall_count", 32'(stall_count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", 32'(in_ready), 32'd1);

    // No dependency until the store reads $9.
    issue(32'h20100000, b); chk("nodep_b0", 32'(b), 32'd0);
    issue(32'h20090003, b); chk("nodep_b1", 32'(b), 32'd0);
    issue(32'hAE090000, b); chk("sw_bubbles", 32'(b), FWD ? 32'd0 : 32'd2);
    chk("sw_stall_count", 32'(stall_count), FWD ? 32'd0 : 32'd2);

    // Two-NOP padded program runs with no bubbles.
    do_reset();
    issue(32'h20090003, b);
    issue(32'h00000020, b);
    issue(32'h00000020, b);
    issue(32'h01295020, b); chk("padded_b", 32'(b), 32'd0);
    chk("padded_count", 32'(stall_count), 32'd0);

    // Load-use.
    do_reset();
    issue(32'h8E0B0000, b);
    issue(32'h016B402A, b); chk("loaduse_b", 32'(b), FWD ? 32'd1 : 32'd2);
    chk("loaduse_count", 32'(stall_count), FWD ? 32'd1 : 32'd2);

    // $0 writes and jumps never stall.
    do_reset();
    issue(32'h00000020, b);
    issue(32'h00000020, b); chk("r0_b", 32'(b), 32'd0);
    issue(32'h20090003, b);
    issue(32'h08000000, b); chk("jump_b", 32'(b), 32'd0);
    chk("r0_jump_count", 32'(stall_count), 32'd0);

    // Reset in the middle of a load-use stall.
    do_reset();
    issue(32'h8E0B0000, b);
    in_instruction = 32'h016B402A;
    tick();
    chk("mid_bubble", 32'(out_stall), 32'd1);
    chk("mid_count1", 32'(stall_count), 32'd1);
    reset = 1'b1;
    tick();
    chk("mid_rst_count", 32'(stall_count), 32'd0);
    reset = 1'b0;
    tick();
    chk("mid_release_valid", 32'(out_valid), 32'd1);
    chk("mid_release_instr", out_instruction, 32'h016B402A);
    chk("mid_release_count", 32'(stall_count), 32'd0);

    // Randomised traffic over a small register pool against the model.
    hold = 1'b0;
    for (int n = 0; n < 600; n++) begin
      logic [5:0] ops [11] = '{6'h00, 6'h08, 6'h0C, 6'h0F, 6'h23, 6'h2B,
                               6'h04, 6'h05, 6'h02, 6'h03, 6'h3F};
      reset = ($urandom_range(0, 99) < 2);
      if (!hold) begin
        in_valid = ($urandom_range(0, 9) < 7);
        in_instruction = {ops[$urandom_range(0, 10)],
                          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          5'($urandom_range(0, 3)), 11'($urandom)};
      end
      tick();
      hold = in_valid && !reset && !exp_v;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
